// File: rtl/bfm_collector_if.sv
// Handshake and bus bundle between the result collector and its host side.
// master drives samples/controls and pkg_ready; slave returns package status.
interface bfm_collector_if #(
  parameter int RES_WIDTH     = 8,
  parameter int PACKAGE_WIDTH = 800,
  parameter int CNT_WIDTH     = 8
);
  logic [RES_WIDTH-1:0]     res_i;
  logic                     res_valid;
  logic                     arm;
  logic                     continuous;
  logic [PACKAGE_WIDTH-1:0] pkg_data;
  logic                     pkg_valid;
  logic                     pkg_ready;
  logic                     busy;
  logic [CNT_WIDTH-1:0]     sample_cnt;
  logic                     overflow;
  logic [15:0]              drop_cnt;

  modport master (
    output res_i, res_valid, arm, continuous, pkg_ready,
    input  pkg_data, pkg_valid, busy, sample_cnt, overflow, drop_cnt
  );

  modport slave (
    input  res_i, res_valid, arm, continuous, pkg_ready,
    output pkg_data, pkg_valid, busy, sample_cnt, overflow, drop_cnt
  );
endinterface

// File: rtl/bfm_collector.sv
// Packs NUM result samples LSB-first into one package word with valid/ready out.
// Ports: clk, reset (async, active-high), bus (bfm_collector_if.slave).
module bfm_collector #(
  parameter int RES_WIDTH     = 8,
  parameter int NUM           = 100,
  parameter int PACKAGE_WIDTH = 800,
  parameter int CNT_WIDTH     = 8
) (
  input logic              clk,
  input logic              reset,
  bfm_collector_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_OUT
  } state_t;

  state_t                   r_state;
  logic [PACKAGE_WIDTH-1:0] r_buf;
  logic [PACKAGE_WIDTH-1:0] r_pkg_data;
  logic                     r_pkg_valid;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_overflow;
  logic [15:0]              r_drop_cnt;

  logic [PACKAGE_WIDTH-1:0] w_slot_buf;
  logic                     w_last;
  logic                     w_free;

  // Collection buffer with the current sample merged into its slot,
  // so the final sample can go straight into pkg_data.
  always_comb begin
    w_slot_buf = r_buf;
    w_slot_buf[r_cnt*RES_WIDTH +: RES_WIDTH] = bus.res_i;
  end

  assign w_last = (r_cnt == CNT_WIDTH'(NUM - 1));
  assign w_free = !r_pkg_valid || bus.pkg_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_pkg_data  <= '0;
      r_pkg_valid <= 1'b0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      // Accepted package drops valid unless a new load below overrides it.
      if (r_pkg_valid && bus.pkg_ready)
        r_pkg_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.arm) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
          end
        end
        S_COLLECT: begin
          if (bus.res_valid) begin
            if (w_last && w_free) begin
              r_pkg_data  <= w_slot_buf;
              r_pkg_valid <= 1'b1;
              r_cnt       <= '0;
              r_state     <= bus.continuous ? S_COLLECT : S_IDLE;
            end else if (w_last) begin
              r_buf   <= w_slot_buf;
              r_cnt   <= CNT_WIDTH'(NUM);
              r_state <= S_WAIT_OUT;
            end else begin
              r_buf <= w_slot_buf;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WAIT_OUT: begin
          if (bus.res_valid) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF)
              r_drop_cnt <= r_drop_cnt + 16'd1;
          end
          if (w_free) begin
            r_pkg_data  <= r_buf;
            r_pkg_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= bus.continuous ? S_COLLECT : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pkg_data   = r_pkg_data;
  assign bus.pkg_valid  = r_pkg_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.sample_cnt = r_cnt;
  assign bus.overflow   = r_overflow;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule
